uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Captures each byte the receiver presents (8-bit data plus a completion strobe) into a small FIFO.
- Exposes the FIFO to the CPU's memory-mapped peripheral read path: head byte, status flags, sticky overflow and an interrupt request.
- Runs on the same clk as the receiver; no clock-domain crossing.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo_mem.sv | 23 ++
 rtl/uart_rx_fifo.sv | 101 ++++++++++
 tb/tb_uart_rx_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, receive FIFO defaults and register offsets
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam int UART_RX_DEPTH_LOG2 = 3;
  localparam int UART_RX_IRQ_THRESH = 4;

  // Offsets shared with the transmitter and the bus decoder
  localparam logic [7:0] UART_REG_RX_DATA = 8'h00;
  localparam logic [7:0] UART_REG_STATUS  = 8'h04;
  localparam logic [7:0] UART_REG_CTRL    = 8'h08;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// rtl/uart_rx_fifo_mem.sv - receive FIFO storage, synchronous write, asynchronous read
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int ADDR_W = UART_RX_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  uart_byte_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output uart_byte_t        rdata
);

  uart_byte_t r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with flags, sticky overflow and level irq
// Define UART_RX_FIFO_THRESH_IRQ_EN to fire irq at level >= IRQ_THRESH instead of non-empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = UART_RX_DEPTH_LOG2,
  parameter int IRQ_THRESH = UART_RX_IRQ_THRESH
) (
  input  logic                clk,
  input  logic                reset,
  input  uart_byte_t          rx_data,
  input  logic                rx_status,
  input  logic                rd_en,
  input  logic                clear_ovf,
  output uart_byte_t          rd_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  output logic                irq
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};

  if (IRQ_THRESH < 1 || IRQ_THRESH > (1 << DEPTH_LOG2)) begin : g_bad_thresh
    $error("uart_rx_fifo: IRQ_THRESH must lie in 1..DEPTH");
  end

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_rx_status_d;
  logic                  r_overflow;
  logic                  r_irq;

  logic       w_push;
  logic       w_pop;
  logic       w_wr;
  logic       w_drop;
  logic       w_empty;
  logic       w_full;
  logic       w_irq_cond;
  uart_byte_t w_head;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == DEPTH_L);
  assign w_push  = rx_status & ~r_rx_status_d;
  assign w_pop   = rd_en & ~w_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  localparam logic [DEPTH_LOG2:0] THRESH_L = (DEPTH_LOG2+1)'(IRQ_THRESH);
  assign w_irq_cond = r_overflow | (r_level >= THRESH_L);
`else
  assign w_irq_cond = r_overflow | ~w_empty;
`endif

  uart_rx_fifo_mem #(
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr),
    .waddr (r_wr_ptr),
    .wdata (rx_data),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_rx_status_d <= 1'b0;
      r_overflow    <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_rx_status_d <= rx_status;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_wr && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (w_pop && !w_wr) r_level <= r_level - LVL_ONE;
      // A fresh drop outranks a clear on the same edge
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
      r_irq <= w_irq_cond;
    end
  end

  assign rd_data  = w_empty ? 8'h00 : w_head;
  assign empty    = w_empty;
  assign full     = w_full;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with directed vectors
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rd_en;
  logic       clear_ovf;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] level;
  logic       overflow;
  logic       irq;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rd_en     (rd_en),
    .clear_ovf (clear_ovf),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_irq(input string nm, input logic exp_any, input logic exp_thresh);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    chk(nm, irq, exp_thresh);
`else
    chk(nm, irq, exp_any);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    rx_data   = b;
    rx_status = 1'b1;
    tick();
    rx_status = 1'b0;
    tick();
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic pop_byte;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Monitor: every accepted pop presents a head byte that must match the scoreboard
  always @(negedge clk) begin
    if (reset && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h expected none", rd_data);
      end else begin
        chk("pop_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_status = 1'b0;
    rd_en     = 1'b0;
    clear_ovf = 1'b0;
    tick();
    tick();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_irq", irq, 1'b0);
    reset = 1'b1;
    tick();

    // Single byte, one-cycle strobe
    rx_data   = 8'hA5;
    rx_status = 1'b1;
    tick();
    chk("single_rd_data", rd_data, 8'hA5);
    chk("single_empty", empty, 1'b0);
    chk("single_level", level, 4'd1);
    rx_status = 1'b0;
    exp_q.push_back(8'hA5);
    tick();
    chk_irq("single_irq", 1'b1, 1'b0);
    pop_byte();
    chk("single_pop_empty", empty, 1'b1);
    chk("single_pop_rd_data", rd_data, 8'h00);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_when_empty_level", level, 4'd0);

    // Held strobe pushes exactly once
    rx_data   = 8'h3C;
    rx_status = 1'b1;
    repeat (5) tick();
    rx_status = 1'b0;
    tick();
    exp_q.push_back(8'h3C);
    chk("held_level", level, 4'd1);
    pop_byte();

    // Fill, overflow, drain, wrap
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    chk("fill_full", full, 1'b1);
    chk("fill_level", level, 4'd8);
    chk("fill_overflow", overflow, 1'b0);
    push_byte(8'h09, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_level", level, 4'd8);
    for (int i = 0; i < 8; i++) pop_byte();
    chk("drain_empty", empty, 1'b1);
    chk_irq("drain_irq_ovf", 1'b1, 1'b1);
    push_byte(8'h10, 1'b1);
    push_byte(8'h11, 1'b1);
    chk("wrap_level", level, 4'd2);
    pop_byte();
    pop_byte();
    chk("wrap_empty", empty, 1'b1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    chk("clear_ovf", overflow, 1'b0);
    tick();
    chk_irq("idle_irq", 1'b0, 1'b0);

    // Push and pop on the same edge while full
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
    rx_data   = 8'hEE;
    rx_status = 1'b1;
    rd_en     = 1'b1;
    tick();
    rx_status = 1'b0;
    rd_en     = 1'b0;
    exp_q.push_back(8'hEE);
    chk("simul_overflow", overflow, 1'b0);
    chk("simul_level", level, 4'd8);
    chk("simul_full", full, 1'b1);
    tick();

    // Clear and new overflow on the same edge
    push_byte(8'hF0, 1'b0);
    chk("ovf2_flag", overflow, 1'b1);
    rx_data   = 8'hF1;
    rx_status = 1'b1;
    clear_ovf = 1'b1;
    tick();
    rx_status = 1'b0;
    clear_ovf = 1'b0;
    chk("clear_vs_ovf", overflow, 1'b1);
    chk("clear_vs_ovf_level", level, 4'd8);
    tick();
    for (int i = 0; i < 8; i++) pop_byte();
    chk("simul_drain_empty", empty, 1'b1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    tick();
    chk_irq("clean_irq", 1'b0, 1'b0);

    // Threshold behaviour: irq follows level one edge late
    push_byte(8'h30, 1'b1);
    push_byte(8'h31, 1'b1);
    push_byte(8'h32, 1'b1);
    chk_irq("thr_3_irq", 1'b1, 1'b0);
    push_byte(8'h33, 1'b1);
    chk_irq("thr_4_irq", 1'b1, 1'b1);
    pop_byte();
    chk_irq("thr_pop_irq_same", 1'b1, 1'b1);
    tick();
    chk_irq("thr_pop_irq", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) pop_byte();
    chk("thr_drain_empty", empty, 1'b1);

    // Asynchronous reset mid-operation with a stored overflow
    for (int i = 0; i < 8; i++) push_byte(8'h50 + 8'(i), 1'b0);
    push_byte(8'h58, 1'b0);
    chk("pre_rst_overflow", overflow, 1'b1);
    chk_irq("pre_rst_irq", 1'b1, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk("async_rst_empty", empty, 1'b1);
    chk("async_rst_level", level, 4'd0);
    chk("async_rst_rd_data", rd_data, 8'h00);
    chk("async_rst_overflow", overflow, 1'b0);
    chk("async_rst_irq", irq, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    push_byte(8'h77, 1'b1);
    chk("post_rst_rd_data", rd_data, 8'h77);
    pop_byte();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
